// File: rtl/lifo_word_serializer_pkg.sv
// Shared constants for the LIFO drain serializer: FSM encoding and the
// word width it shares with LIFO_buffer.
package lifo_word_serializer_pkg;

    localparam int LIFO_DATA_W = 16;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Bit-counter width; never below 1 so the counter always exists.
    function automatic int cnt_w(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/lifo_piso_shift.sv
// Parallel-in serial-out shifter with bit counter; load wins over shift.
// Output bit is taken from the end the register shifts toward.
module lifo_piso_shift
    import lifo_word_serializer_pkg::*;
#(
    parameter int DATA_W    = LIFO_DATA_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_shift,
    output logic              o_bit,
    output logic              o_first,
    output logic              o_last
);

    localparam int CNT_W = cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] r_sreg;
    logic [CNT_W-1:0]  r_bit_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sreg    <= '0;
            r_bit_cnt <= '0;
        end else if (i_load) begin
            r_sreg    <= i_data;
            r_bit_cnt <= '0;
        end else if (i_shift) begin
            r_sreg    <= MSB_FIRST ? {r_sreg[DATA_W-2:0], 1'b0}
                                   : {1'b0, r_sreg[DATA_W-1:1]};
            r_bit_cnt <= (r_bit_cnt == CNT_LAST) ? '0 : r_bit_cnt + CNT_W'(1);
        end
    end

    assign o_bit   = MSB_FIRST ? r_sreg[DATA_W-1] : r_sreg[0];
    assign o_first = (r_bit_cnt == '0);
    assign o_last  = (r_bit_cnt == CNT_LAST);

endmodule

// File: rtl/lifo_word_serializer.sv
// Pops words from a show-ahead LIFO and streams them bit-serially over
// valid/ready, reloading on the last-bit transfer so words run gap-free.
module lifo_word_serializer
    import lifo_word_serializer_pkg::*;
#(
    parameter int DATA_W    = LIFO_DATA_W,
    parameter bit MSB_FIRST = 1'b1,
    parameter int WCNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              lifo_val,
    input  logic [DATA_W-1:0] lifo_data,
    output logic              lifo_read,
    output logic              ser_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_first,
    output logic              ser_last,
    output logic              busy,
    output logic [WCNT_W-1:0] word_cnt
);

    logic [0:0]        r_state;
    logic [WCNT_W-1:0] r_word_cnt;
    logic              w_shift, w_xfer, w_word_end, w_pop;
    logic              w_bit, w_first, w_last;

    assign w_shift    = (r_state == ST_SHIFT);
    assign w_xfer     = w_shift & ser_ready;
    assign w_word_end = w_xfer & w_last;
    // Gated by reset so the pop strobe is low the instant reset asserts.
    assign w_pop      = reset & enable & lifo_val & (~w_shift | w_word_end);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_word_cnt <= '0;
        end else begin
            if (w_pop)
                r_state <= ST_SHIFT;
            else if (w_word_end)
                r_state <= ST_IDLE;
            if (w_word_end)
                r_word_cnt <= r_word_cnt + WCNT_W'(1);
        end
    end

    lifo_piso_shift #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_load  (w_pop),
        .i_data  (lifo_data),
        .i_shift (w_xfer & ~w_pop),
        .o_bit   (w_bit),
        .o_first (w_first),
        .o_last  (w_last)
    );

    assign lifo_read = w_pop;
    assign ser_valid = w_shift;
    assign busy      = w_shift;
    assign ser_data  = w_shift & w_bit;
    assign ser_first = w_shift & w_first;
    assign ser_last  = w_shift & w_last;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_lifo_word_serializer.sv
// Directed bench: behavioural LIFO feeding two serializers (MSB-first/8-bit
// count, and LSB-first/2-bit count), checked against hand-computed streams.
module tb_lifo_word_serializer;

    logic        clk = 1'b0;
    logic        reset, enable, ser_ready;

    // Stack model 0 -> dut0 (defaults), stack model 1 -> dut1 (LSB first)
    logic [15:0] stk0 [0:15];
    logic [15:0] stk1 [0:15];
    int          sp0 = 0, sp1 = 0;
    logic        pe0 = 1'b0, pe1 = 1'b0;
    logic [15:0] pd0 = '0, pd1 = '0;

    logic        val0, val1, rd0, rd1;
    logic [15:0] dat0, dat1;
    logic        sd0, sv0, sf0, sl0, bz0;
    logic        sd1, sv1, sf1, sl1, bz1;
    logic [7:0]  wc0;
    logic [1:0]  wc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign val0 = (sp0 > 0);
    assign val1 = (sp1 > 0);
    assign dat0 = (sp0 > 0) ? stk0[sp0-1] : '0;
    assign dat1 = (sp1 > 0) ? stk1[sp1-1] : '0;

    always @(posedge clk) begin
        if (pe0) begin
            stk0[sp0] <= pd0;
            sp0       <= sp0 + 1;
        end else if (rd0) begin
            sp0 <= sp0 - 1;
        end
        if (pe1) begin
            stk1[sp1] <= pd1;
            sp1       <= sp1 + 1;
        end else if (rd1) begin
            sp1 <= sp1 - 1;
        end
    end

    lifo_word_serializer dut0 (
        .clk(clk), .reset(reset), .enable(enable),
        .lifo_val(val0), .lifo_data(dat0), .lifo_read(rd0),
        .ser_data(sd0), .ser_valid(sv0), .ser_ready(ser_ready),
        .ser_first(sf0), .ser_last(sl0), .busy(bz0), .word_cnt(wc0)
    );

    lifo_word_serializer #(.DATA_W(16), .MSB_FIRST(1'b0), .WCNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .enable(enable),
        .lifo_val(val1), .lifo_data(dat1), .lifo_read(rd1),
        .ser_data(sd1), .ser_valid(sv1), .ser_ready(ser_ready),
        .ser_first(sf1), .ser_last(sl1), .busy(bz1), .word_cnt(wc1)
    );

    typedef struct {
        logic ready;
        logic e_valid;
        logic e_data;
        logic e_first;
        logic e_last;
    } vec_t;

    vec_t tbl [0:16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int s, input logic [15:0] d);
        if (s == 0) begin pe0 = 1'b1; pd0 = d; end
        else        begin pe1 = 1'b1; pd1 = d; end
        @(negedge clk);
        pe0 = 1'b0;
        pe1 = 1'b0;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] wv;
        logic        pv, pr, pd, pf, pl;
        int          n, cyc;

        reset = 1'b0; enable = 1'b0; ser_ready = 1'b0;

        w = 16'hA5C3;
        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, 1'b1, w[15-i], (i == 0), (i == 15)};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_lifo_read", rd0, 0);
        chk("rst_valid", sv0, 0);
        chk("rst_busy", bz0, 0);
        chk("rst_first", sf0, 0);
        chk("rst_word_cnt", wc0, 0);
        @(negedge clk);
        reset = 1'b1;

        // 1: single word, table driven
        push(0, 16'hA5C3);
        enable = 1'b1; ser_ready = 1'b1;
        #1 chk("c1_pop", rd0, 1);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            ser_ready = tbl[i].ready;
            #1;
            chk($sformatf("c1_valid[%0d]", i), sv0, tbl[i].e_valid);
            chk($sformatf("c1_data[%0d]", i),  sd0, tbl[i].e_data);
            chk($sformatf("c1_first[%0d]", i), sf0, tbl[i].e_first);
            chk($sformatf("c1_last[%0d]", i),  sl0, tbl[i].e_last);
        end
        chk("c1_word_cnt", wc0, 1);
        chk("c1_lifo_val", val0, 0);
        chk("c1_busy", bz0, 0);

        // 2: three words back to back, LIFO order
        do_reset();
        push(0, 16'd1); push(0, 16'd2); push(0, 16'd3);
        enable = 1'b1; ser_ready = 1'b1;
        #1 chk("c2_pop", rd0, 1);
        for (int k = 0; k < 3; k++) begin
            wv = (k == 0) ? 16'd3 : (k == 1) ? 16'd2 : 16'd1;
            for (int j = 0; j < 16; j++) begin
                @(negedge clk); #1;
                chk($sformatf("c2_valid[%0d][%0d]", k, j), sv0, 1);
                chk($sformatf("c2_data[%0d][%0d]", k, j), sd0, wv[15-j]);
                if (j == 15) chk($sformatf("c2_reload[%0d]", k), rd0, (k < 2));
            end
        end
        @(negedge clk); #1;
        chk("c2_valid_end", sv0, 0);
        chk("c2_word_cnt", wc0, 3);

        // 3: ready alternating; outputs must hold while stalled
        do_reset();
        push(0, 16'hA5C3);
        enable = 1'b1; ser_ready = 1'b1;
        n = 0; cyc = 0; pv = 1'b0; pr = 1'b0; pd = 1'b0; pf = 1'b0; pl = 1'b0;
        while (n < 16 && cyc < 200) begin
            @(negedge clk);
            ser_ready = ~ser_ready;
            cyc++;
            #1;
            if (pv && !pr) begin
                chk($sformatf("c3_hold_data[%0d]", cyc),  sd0, pd);
                chk($sformatf("c3_hold_first[%0d]", cyc), sf0, pf);
                chk($sformatf("c3_hold_last[%0d]", cyc),  sl0, pl);
            end
            if (sv0 && ser_ready) begin
                chk($sformatf("c3_data[%0d]", n),  sd0, w[15-n]);
                chk($sformatf("c3_first[%0d]", n), sf0, (n == 0));
                chk($sformatf("c3_last[%0d]", n),  sl0, (n == 15));
                n++;
            end
            pv = sv0; pr = ser_ready; pd = sd0; pf = sf0; pl = sl0;
        end
        chk("c3_bits_done", n, 16);
        @(negedge clk); #1;
        chk("c3_word_cnt", wc0, 1);

        // 4: enable gating, then enable dropped at bit 5
        do_reset();
        push(0, 16'h1234); push(0, 16'h8001);
        ser_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk($sformatf("c4_no_pop[%0d]", i), rd0, 0);
            chk($sformatf("c4_no_valid[%0d]", i), sv0, 0);
        end
        enable = 1'b1;
        #1 chk("c4_pop", rd0, 1);
        wv = 16'h8001;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (j == 5) enable = 1'b0;
            #1;
            chk($sformatf("c4_data[%0d]", j), sd0, wv[15-j]);
            if (j == 15) chk("c4_no_reload", rd0, 0);
        end
        @(negedge clk); #1;
        chk("c4_valid_end", sv0, 0);
        chk("c4_stack_left", sp0, 1);
        chk("c4_word_cnt", wc0, 1);

        // 5: async reset at bit 7, next word sent intact afterwards
        push(0, 16'hC3A5);
        enable = 1'b1;
        for (int j = 0; j < 8; j++) @(negedge clk);
        #1 chk("c5_bit7_data", sd0, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("c5_rst_valid", sv0, 0);
        chk("c5_rst_data", sd0, 0);
        chk("c5_rst_busy", bz0, 0);
        chk("c5_rst_last", sl0, 0);
        chk("c5_rst_pop", rd0, 0);
        chk("c5_rst_word_cnt", wc0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("c5_stack_left", sp0, 1);
        reset = 1'b1;
        #1 chk("c5_pop_after", rd0, 1);
        wv = 16'h1234;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk); #1;
            chk($sformatf("c5_data[%0d]", j), sd0, wv[15-j]);
            chk($sformatf("c5_first[%0d]", j), sf0, (j == 0));
        end
        @(negedge clk); #1;
        chk("c5_word_cnt", wc0, 1);
        chk("c5_valid_end", sv0, 0);

        // 6: LSB first, 2-bit wrapping word counter
        do_reset();
        for (int k = 0; k < 5; k++) push(1, 16'h0001);
        enable = 1'b1; ser_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 16; j++) begin
                @(negedge clk); #1;
                chk($sformatf("c6_valid[%0d][%0d]", k, j), sv1, 1);
                chk($sformatf("c6_data[%0d][%0d]", k, j), sd1, (j == 0));
                if (j == 0 && k > 0)
                    chk($sformatf("c6_word_cnt[%0d]", k), wc1, k % 4);
            end
        end
        @(negedge clk); #1;
        chk("c6_word_cnt_final", wc1, 1);
        chk("c6_valid_end", sv1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
